// File: rtl/edulent_pkg.sv
// Shared widths, opcode encoding and FSM states for the Edulent 8-bit accumulator CPU.
package edulent_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    // Opcodes B..E are unassigned and execute as NOP.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_IN  = 4'h9,
        OP_OUT = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

endpackage

// File: rtl/edulent_alu.sv
// Combinational add/subtract unit; subtract is A + ~B + 1 so carry-out means "no borrow".
module edulent_alu
    import edulent_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              z
);

    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;

    assign b_op = sub ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    assign y    = sum[DATA_W-1:0];
    assign c    = sum[DATA_W];
    assign z    = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/edulent_top.sv
// Edulent CPU top: 16x8 unified memory, accumulator, C/Z flags and a two-cycle
// FETCH/EXEC sequencer with a terminal HALT state.
module edulent_top
    import edulent_pkg::*;
#(
    parameter string INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [DATA_W-1:0] i_in,
    output logic [DATA_W-1:0] o_out
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic              c_flag;
    logic              z_flag;

    opcode_e           op;
    logic [ADDR_W-1:0] arg;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_we;

    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
    logic              alu_z;

    assign op  = opcode_e'(ir[7:4]);
    assign arg = ir[ADDR_W-1:0];

    // A single read port serves both instruction fetch and operand access.
    assign rd_addr = (state == ST_FETCH) ? pc : arg;
    assign mem_rd  = mem[rd_addr];
    assign mem_we  = (state == ST_EXEC) && (op == OP_STA);

    edulent_alu u_alu (
        .a   (acc),
        .b   (mem_rd),
        .sub (op == OP_SUB),
        .y   (alu_y),
        .c   (alu_c),
        .z   (alu_z)
    );

    // NOTE: memory has no reset so it keeps its image across resets; gating the
    // write with i_rstn drops an STA that coincides with reset assertion.
    always_ff @(posedge i_clk) begin
        if (i_rstn && mem_we) begin
            mem[arg] <= acc;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            o_out  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= mem_rd;
                    pc    <= pc + 1'b1;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (op)
                        OP_LDA: acc <= mem_rd;
                        OP_ADD, OP_SUB: begin
                            acc    <= alu_y;
                            c_flag <= alu_c;
                            z_flag <= alu_z;
                        end
                        OP_LDI: acc <= {{(DATA_W-ADDR_W){1'b0}}, arg};
                        OP_JMP: pc  <= arg;
                        OP_JC:  if (c_flag) pc <= arg;
                        OP_JZ:  if (z_flag) pc <= arg;
                        OP_IN:  acc   <= i_in;
                        OP_OUT: o_out <= acc;
                        OP_HLT: state <= ST_HALT;
                        default: ;
                    endcase
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_edulent_top.sv
// Directed programs for edulent_top; expected o_out values go into a queue that
// a separate monitor pops whenever the output port changes.
module tb_edulent_top;
    import edulent_pkg::*;

    logic       i_clk  = 1'b0;
    logic       i_rstn = 1'b1;
    logic [7:0] i_in   = 8'h00;
    logic [7:0] o_out;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    edulent_top #(.INIT_FILE("")) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_in   (i_in),
        .o_out  (o_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Output monitor: every change of o_out outside reset is one observed result.
    initial begin : monitor
        logic [7:0] last;
        last = 8'h00;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                last = 8'h00;
            end else if (o_out !== last) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected no change", o_out);
                end else begin
                    check("out_seq", o_out, exp_q.pop_front());
                end
                last = o_out;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic clear_mem();
        for (int i = 0; i < MEM_DEPTH; i++) dut.mem[i] = 8'h00;
    endtask

    task automatic poke(input int addr, input logic [7:0] val);
        dut.mem[addr] = val;
    endtask

    task automatic enter_rst();
        @(negedge i_clk);
        i_rstn = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk);
            #1;
            if (dut.state == ST_HALT) break;
        end
        check(name, dut.state, ST_HALT);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge i_clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        // Reset with a toggling input port.
        #1 i_rstn = 1'b0;
        clear_mem();
        repeat (4) begin
            #5 i_in = ~i_in;
        end
        check("rst_out", o_out, 8'h00);
        check("rst_pc", dut.pc, 4'h0);
        check("rst_state", dut.state, ST_FETCH);
        release_rst();
        repeat (8) @(posedge i_clk);
        #1;
        check("nop_out", o_out, 8'h00);
        check("nop_pc", dut.pc, 4'h4);

        // Echo program: IN, OUT, JMP 0.
        enter_rst();
        clear_mem();
        poke(0, 8'h90); poke(1, 8'hA0); poke(2, 8'h60);
        i_in = 8'h5A;
        exp_q.push_back(8'h5A);
        release_rst();
        repeat (3) @(posedge i_clk);
        #1 check("echo_edge3", o_out, 8'h00);
        @(posedge i_clk);
        #1 check("echo_edge4", o_out, 8'h5A);
        i_in = 8'hC3;
        exp_q.push_back(8'hC3);
        repeat (5) @(posedge i_clk);
        #1 check("echo_edge9", o_out, 8'h5A);
        @(posedge i_clk);
        #1 check("echo_edge10", o_out, 8'hC3);
        wait_drain("echo_drain", 20);

        // LDI 7; ADD F (FC) -> 03 with carry; OUT; HLT.
        enter_rst();
        clear_mem();
        poke(0, 8'h57); poke(1, 8'h2F); poke(2, 8'hA0); poke(3, 8'hF0); poke(15, 8'hFC);
        exp_q.push_back(8'h03);
        release_rst();
        wait_halt("add_halt", 50);
        check("add_acc", dut.acc, 8'h03);
        check("add_c", dut.c_flag, 1'b1);
        check("add_z", dut.z_flag, 1'b0);
        repeat (10) @(posedge i_clk);
        #1;
        check("add_still_halt", dut.state, ST_HALT);
        check("add_out_stable", o_out, 8'h03);
        wait_drain("add_drain", 20);

        // Countdown: LDI 3; OUT; SUB F; JZ 6; JMP 1; NOP; HLT with M[F]=01.
        enter_rst();
        clear_mem();
        poke(0, 8'h53); poke(1, 8'hA0); poke(2, 8'h3F); poke(3, 8'h86);
        poke(4, 8'h61); poke(6, 8'hF0); poke(15, 8'h01);
        exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        release_rst();
        wait_halt("cnt_halt", 100);
        check("cnt_acc", dut.acc, 8'h00);
        check("cnt_z", dut.z_flag, 1'b1);
        check("cnt_c", dut.c_flag, 1'b1);
        check("cnt_pc", dut.pc, 4'h7);
        check("cnt_out", o_out, 8'h01);
        wait_drain("cnt_drain", 20);

        // Store/reload: LDI A; STA E; LDI 0; LDA E; OUT; HLT.
        enter_rst();
        clear_mem();
        poke(0, 8'h5A); poke(1, 8'h4E); poke(2, 8'h50); poke(3, 8'h1E);
        poke(4, 8'hA0); poke(5, 8'hF0);
        exp_q.push_back(8'h0A);
        release_rst();
        wait_halt("sta_halt", 50);
        check("sta_mem", dut.mem[14], 8'h0A);
        check("sta_out", o_out, 8'h0A);
        wait_drain("sta_drain", 20);

        // Asynchronous reset in the middle of a clock period during the echo program.
        enter_rst();
        clear_mem();
        poke(0, 8'h90); poke(1, 8'hA0); poke(2, 8'h60);
        i_in = 8'h5A;
        exp_q.push_back(8'h5A);
        release_rst();
        repeat (6) @(posedge i_clk);
        #3 i_rstn = 1'b0;
        #1;
        check("arst_out", o_out, 8'h00);
        check("arst_pc", dut.pc, 4'h0);
        check("arst_state", dut.state, ST_FETCH);
        wait_drain("arst_drain1", 10);
        exp_q.push_back(8'h5A);
        release_rst();
        repeat (4) @(posedge i_clk);
        #1 check("arst_restart", o_out, 8'h5A);
        wait_drain("arst_drain2", 20);

        // Reset after the STA has executed: memory keeps the stored value.
        enter_rst();
        clear_mem();
        poke(0, 8'h5A); poke(1, 8'h4E); poke(2, 8'h50); poke(3, 8'h1E);
        poke(4, 8'hA0); poke(5, 8'hF0);
        release_rst();
        repeat (5) @(posedge i_clk);
        #2 i_rstn = 1'b0;
        #1;
        check("keep_mem", dut.mem[14], 8'h0A);
        check("keep_out", o_out, 8'h00);
        exp_q.push_back(8'h0A);
        release_rst();
        wait_halt("keep_halt", 50);
        check("keep_rerun_out", o_out, 8'h0A);
        wait_drain("keep_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
